// File: rtl/sw_debounce.sv
// Switch debouncer: two-flop synchronizer followed by a settle-count FSM that
// accepts a new vector only after it has held steady for STABLE_CYCLES cycles.
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic             busy
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] cand_r;
  logic [CW-1:0]    cnt_r;
  state_t           state_r;

  state_t           state_s;
  logic [WIDTH-1:0] cand_s;
  logic [CW-1:0]    cnt_s;
  logic [WIDTH-1:0] out_s;
  logic             changed_s;

  // Synchronizer plus FSM state, candidate, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      cand_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      sw_out  <= {WIDTH{1'b0}};
      changed <= 1'b0;
      state_r <= IDLE;
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
      cand_r  <= cand_s;
      cnt_r   <= cnt_s;
      sw_out  <= out_s;
      changed <= changed_s;
      state_r <= state_s;
    end
  end

  // Next-state logic; an abort back to the current output wins over a restart
  always_comb begin
    state_s   = state_r;
    cand_s    = cand_r;
    cnt_s     = cnt_r;
    out_s     = sw_out;
    changed_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync2_r != sw_out) begin
          cand_s  = sync2_r;
          cnt_s   = {CW{1'b0}};
          state_s = SETTLE;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (sync2_r == sw_out) begin
          state_s = IDLE;
        end else if (sync2_r != cand_r) begin
          cand_s = sync2_r;
          cnt_s  = {CW{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
          out_s     = cand_r;
          changed_s = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  assign busy = (state_r == SETTLE);

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios plus random bouncing
// input, compared every cycle against a sliding-window behavioural model.
module tb_sw_debounce;

  localparam int W  = 8;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_in = 8'h00;
  logic [W-1:0] sw_out;
  logic         changed;
  logic         busy;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
    .sw_out(sw_out), .changed(changed), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit chk_en = 1'b0;
  bit seen_c0 = 1'b0;

  // Model: raw input samples, one per edge; the FSM at a given edge sees the
  // sample from two edges earlier.
  logic [W-1:0] q[$];
  logic [W-1:0] m_out;
  logic         m_chg;
  logic         m_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SC + 3; i++) q.push_back(8'h00);
    m_out  = 8'h00;
    m_chg  = 1'b0;
    m_busy = 1'b0;
  endtask

  // A new value is accepted when the last SC+1 synchronized samples all equal
  // it and it differs from the current output.
  task automatic model_edge(input logic [W-1:0] v);
    logic [W-1:0] s;
    bit stable;
    bit upd;
    s = q[q.size()-2];
    stable = 1'b1;
    for (int i = 0; i <= SC; i++)
      if (q[q.size()-2-i] != s) stable = 1'b0;
    upd    = stable && (s != m_out);
    m_busy = (s != m_out) && !upd;
    m_chg  = upd;
    if (upd) m_out = s;
    q.push_back(v);
    void'(q.pop_front());
  endtask

  task automatic step(input logic [W-1:0] v);
    sw_in = v;
    @(posedge clk);
    if (rst_n) model_edge(v);
    else model_reset();
    @(negedge clk);
    #1;
  endtask

  // Compare process: DUT against model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sw_out", 32'(sw_out), 32'(m_out));
      chk("changed", 32'(changed), 32'(m_chg));
      chk("busy", 32'(busy), 32'(m_busy));
      if (changed === 1'b1) pulses++;
      if (sw_out === 8'hC0) seen_c0 = 1'b1;
    end
  end

  initial begin
    int p0;
    logic [W-1:0] base;
    logic [W-1:0] v;

    // Reset held with switches high, then released with switches low
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) step(8'hFF);
    chk("rst_sw_out", 32'(sw_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(8'h00);
    chk("rst_no_pulse", 32'(pulses), 32'h0);

    // Glitch shorter than the qualification window
    for (int i = 0; i < 3; i++) step(8'h01);
    for (int i = 0; i < 10; i++) step(8'h00);
    chk("glitch_out", 32'(sw_out), 32'h0);
    chk("glitch_no_pulse", 32'(pulses), 32'h0);
    chk("glitch_busy", 32'(busy), 32'h0);

    // Clean edge with hand-computed latency; j counts edges after edge k
    p0 = pulses;
    for (int j = 0; j < 10; j++) begin
      step(8'h80);
      if (j == 1) chk("clean_busy_k1", 32'(busy), 32'h0);
      if (j == 2) chk("clean_busy_k2", 32'(busy), 32'h1);
      if (j == 5) chk("clean_out_k5", 32'(sw_out), 32'h00);
      if (j == 5) chk("clean_busy_k5", 32'(busy), 32'h1);
      if (j == 6) chk("clean_out_k6", 32'(sw_out), 32'h80);
      if (j == 6) chk("clean_chg_k6", 32'(changed), 32'h1);
      if (j == 7) chk("clean_chg_k7", 32'(changed), 32'h0);
      if (j == 7) chk("clean_busy_k7", 32'(busy), 32'h0);
    end
    chk("clean_one_pulse", 32'(pulses - p0), 32'h1);

    // Return to zero, then bounce 80,80,C0,80...
    for (int i = 0; i < 10; i++) step(8'h00);
    p0 = pulses;
    step(8'h80);
    step(8'h80);
    step(8'hC0);
    for (int j = 0; j < 12; j++) begin
      step(8'h80);
      if (j == 5) chk("bounce_out_early", 32'(sw_out), 32'h00);
      if (j == 6) chk("bounce_out_k6", 32'(sw_out), 32'h80);
    end
    chk("bounce_one_pulse", 32'(pulses - p0), 32'h1);
    chk("bounce_no_c0", 32'(seen_c0), 32'h0);

    // Multi-bit change in one step
    p0 = pulses;
    for (int i = 0; i < 10; i++) step(8'h05);
    chk("multi_out", 32'(sw_out), 32'h05);
    chk("multi_one_pulse", 32'(pulses - p0), 32'h1);

    // Reset two cycles into SETTLE of 0x80 -> 0x00
    for (int i = 0; i < 10; i++) step(8'h80);
    for (int i = 0; i < 4; i++) step(8'h00);
    chk("mid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_out_zero", 32'(sw_out), 32'h0);
    chk("mid_chg_zero", 32'(changed), 32'h0);
    chk("mid_busy_zero", 32'(busy), 32'h0);
    step(8'h00);
    step(8'h00);
    rst_n = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 10; i++) step(8'h00);
    chk("mid_no_pulse", 32'(pulses - p0), 32'h0);
    chk("mid_out_after", 32'(sw_out), 32'h0);

    // Random bouncing: hold a base value, occasionally flip bits briefly
    base = 8'h00;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) base = 8'($urandom);
      v = base;
      if ($urandom_range(0, 1) == 1) v = base ^ (8'h01 << $urandom_range(0, 7));
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) step(v);
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) step(base);
    end
    for (int i = 0; i < 10; i++) step(base);
    chk("rand_final_out", 32'(sw_out), 32'(base));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input conditioning stage placed directly upstream of the 8-input priority encoder. It synchronizes the raw slide-switch vector from the board into the `clk` domain, rejects contact bounce with a settle counter, and presents a clean, glitch-free vector on `sw_out`. That vector drives the encoder's data input. A one-cycle `changed` pulse and a `busy` flag let downstream logic know when the value has been updated.

## Interface
- `WIDTH`, default 8: number of switch bits.
- `STABLE_CYCLES`, default 16: consecutive cycles a new synchronized value must hold before it is accepted. Legal range is ≥ 2. The counter width is `$clog2(STABLE_CYCLES)`.

- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `sw_in`  input  WIDTH  raw switch levels, asynchronous to `clk`, may bounce.
- `sw_out`  output  WIDTH  debounced switch vector, registered.
- `changed`  output  1  registered pulse, high for exactly one cycle when `sw_out` takes a new value.
- `busy`  output  1  high while the FSM is in SETTLE, i.e. a candidate value is being qualified.

## Operation
- **Synchronizer:** two flops in series on the full vector, `sync1 <= sw_in` and `sync2 <= sync1`. Only `sync2` is used past this point.
- **Registers:** `cand` (WIDTH), `cnt`, `sw_out`, `changed`, and `state` ∈ {IDLE, SETTLE}.
- **IDLE:**
  - If `sync2 != sw_out`: `cand <= sync2`, `cnt <= 0`, go to SETTLE.
  - Otherwise hold.
- **SETTLE:** conditions are checked in this priority order.
  1. `sync2 == sw_out`: abort. Go to IDLE with no update and no pulse.
  2. `sync2 != cand`: restart with `cand <= sync2`, `cnt <= 0`, and stay in SETTLE.
  3. `cnt == STABLE_CYCLES-1`: `sw_out <= cand`, `changed <= 1`, go to IDLE.
  4. Otherwise: `cnt <= cnt + 1`.
- **`changed`:** defaults to 0 every cycle and is set only in case 3. Back-to-back pulses are impossible, because a new SETTLE needs at least STABLE_CYCLES cycles.
- **`busy`:** `busy = (state == SETTLE)`, decoded from the state register (no extra flop).
- **Multi-bit changes:** the vector is qualified as a whole. Any bit moving during SETTLE restarts the count for all bits.
- **Non-zero switches at reset release:** the block settles normally and produces one `changed` pulse. This is intended.
- **Arithmetic:** `cnt` never exceeds STABLE_CYCLES-1, so it cannot wrap.

## Timing
- **Reset values** (asynchronous on `rst_n` low):
  - `sync1`, `sync2`, `cand`, `cnt`, `sw_out`: 0.
  - `changed`: 0, `state`: IDLE, so `busy` is 0.
- **Reset mid-SETTLE:** all state clears immediately and no pulse is produced. After release, qualification restarts from scratch.
- **Latency:** a value first captured by `sync1` at edge k, and held, appears on `sw_out` at edge k+STABLE_CYCLES+2. `changed` is high for the cycle that follows that same edge.
  - `busy` rises at edge k+2.
  - `busy` falls at edge k+STABLE_CYCLES+2.
- **Bounce:** any transition of `sync2` during SETTLE restarts the latency from that transition.
- **Glitches:** a glitch that returns to the original value before qualifying produces no output activity. `busy` still pulses high while it is being evaluated.
- **No handshake:** `changed` is informational and is not acknowledged.

## Test plan
All scenarios use WIDTH=8 and STABLE_CYCLES=4.
- **Reset:** hold `rst_n`=0 with `sw_in`=0xFF, release and drive 0x00. Required: `sw_out`=0x00, `changed`=0, `busy`=0 throughout; no pulse ever occurs.
- **Clean edge:** change `sw_in` from 0x00 to 0x80, first sampled at edge k. Required:
  - `busy`=1 from edge k+2.
  - `sw_out`=0x80 at edge k+6, with `changed`=1 for exactly one cycle.
  - `busy`=0 after edge k+6.
- **Glitch rejection:** drive `sw_in`=0x01 for 3 cycles, then 0x00. Required: `sw_out` stays 0x00, `changed` never asserts, `busy` returns to 0.
- **Bounce restart:** drive 0x00→0x80 for 2 cycles, then 0xC0 for 1 cycle, then 0x80 held. Required: exactly one `changed` pulse, and `sw_out`=0x80 four cycles after `sync2` last transitions plus 2 synchronizer cycles. 0xC0 never appears on `sw_out`.
- **Multi-bit change:** drive 0x80→0x05 in one step. Required: `sw_out` goes directly from 0x80 to 0x05 with a single pulse and no intermediate values.
- **Reset mid-settle:** assert `rst_n`=0 two cycles into SETTLE of 0x80→0x00, with `sw_in` held at 0x00. Required:
  - Outputs are 0 immediately.
  - After release, no `changed` pulse, since `sync2` equals `sw_out`.
